// File: rtl/lfsr_seq_ctrl.sv
// Run sequencer for an 8-bit XNOR LFSR (taps 7,3): loads a seed, streams a
// programmed number of states over valid/ready, and flags done/abort/bad-seed.
module lfsr_seq_ctrl #(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       cfg_seed_i,
    input  logic [LEN_W-1:0] cfg_len_i,
    input  logic             start_i,
    input  logic             abort_i,
    output logic [7:0]       out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_seed_o,
    output logic [LEN_W-1:0] count_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [7:0]       lfsr_q;
    logic [LEN_W-1:0] remaining_q;
    logic [LEN_W-1:0] count_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic [7:0]       lfsr_step;
    logic             beat;
    logic             start_ok;
    logic [LEN_W-1:0] count_inc;

    always_comb begin
        lfsr_step = {lfsr_q[6:0], ~(lfsr_q[7] ^ lfsr_q[3])};
        beat      = valid_q & out_ready_i;
        start_ok  = start_i & ~abort_i;
        count_inc = (count_q == {LEN_W{1'b1}}) ? count_q : count_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            lfsr_q      <= 8'h00;
            remaining_q <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        // Zero-length run wins over the seed check.
                        if (cfg_len_i == '0) begin
                            done_q  <= 1'b1;
                            count_q <= '0;
                        end else if (cfg_seed_i == 8'hFF) begin
                            err_q <= 1'b1;
                        end else begin
                            lfsr_q      <= cfg_seed_i;
                            remaining_q <= cfg_len_i;
                            count_q     <= '0;
                            valid_q     <= 1'b1;
                            busy_q      <= 1'b1;
                            state_q     <= StRun;
                        end
                    end
                end
                StRun: begin
                    // Abort beats a simultaneous handshake; that beat is dropped.
                    if (abort_i) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (beat) begin
                        lfsr_q      <= lfsr_step;
                        remaining_q <= remaining_q - 1'b1;
                        count_q     <= count_inc;
                        if (remaining_q == LEN_W'(1)) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign out_data_o  = lfsr_q;
    assign out_valid_o = valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_seed_o  = err_q;
    assign count_o     = count_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl: directed vector table, async-reset and max-length
// sequences, then random traffic against a queue-based reference model.
module tb_lfsr_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cfg_seed;
    logic [7:0] cfg_len;
    logic       start, abort, out_ready;
    logic [7:0] out_data;
    logic       out_valid, busy, done, err_seed;
    logic [7:0] count;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lfsr_seq_ctrl #(.LEN_W(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cfg_seed_i (cfg_seed),
        .cfg_len_i  (cfg_len),
        .start_i    (start),
        .abort_i    (abort),
        .out_data_o (out_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .busy_o     (busy),
        .done_o     (done),
        .err_seed_o (err_seed),
        .count_o    (count)
    );

    typedef struct {
        logic       start, abort, ready;
        logic [7:0] seed, len;
        logic       valid;
        logic [7:0] data;
        logic       busy, done, err;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic s, logic a, logic r, logic [7:0] sd, logic [7:0] ln,
                                logic v, logic [7:0] d, logic b, logic dn, logic e,
                                logic [7:0] c);
        vec_t x;
        x.start = s; x.abort = a; x.ready = r; x.seed = sd; x.len = ln;
        x.valid = v; x.data = d; x.busy = b; x.done = dn; x.err = e; x.cnt = c;
        return x;
    endfunction

    function automatic logic [19:0] obs();
        return {out_valid, out_data, busy, done, err_seed, count};
    endfunction

    task automatic chk(input string name, input logic [19:0] got, input logic [19:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got v=%b d=%h busy=%b done=%b err=%b cnt=%0d, required v=%b d=%h busy=%b done=%b err=%b cnt=%0d",
                     name, got[19], got[18:11], got[10], got[9], got[8], got[7:0],
                     exp[19], exp[18:11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    task automatic apply(input logic s, input logic a, input logic r,
                         input logic [7:0] sd, input logic [7:0] ln);
        start = s; abort = a; out_ready = r; cfg_seed = sd; cfg_len = ln;
        @(posedge clk);
        #1;
    endtask

    // LFSR rule: shift left, feed in 1 when bits 7 and 3 agree.
    function automatic logic [7:0] nxt(logic [7:0] w);
        int fb;
        fb = (w[7] == w[3]) ? 1 : 0;
        return 8'(((int'(w) * 2) % 256) + fb);
    endfunction

    // Reference model: a run is the list of states still to be shown, plus the
    // state the generator lands on after the final word.
    bit         m_run, m_in_done, m_done_p, m_err_p;
    logic [7:0] m_words[$];
    logic [7:0] m_count;

    function automatic void m_reset();
        m_run = 0; m_in_done = 0; m_done_p = 0; m_err_p = 0; m_count = 0;
        m_words.delete();
        m_words.push_back(8'h00);
    endfunction

    function automatic void m_clock(bit s, bit a, bit r, logic [7:0] sd, logic [7:0] ln);
        logic [7:0] w;
        m_done_p = 0;
        m_err_p  = 0;
        if (m_in_done) begin
            m_in_done = 0;
        end else if (m_run) begin
            if (a) m_run = 0;
            else if (r) begin
                void'(m_words.pop_front());
                if (m_count != 8'hFF) m_count = m_count + 8'd1;
                if (m_words.size() == 1) begin
                    m_run = 0; m_in_done = 1; m_done_p = 1;
                end
            end
        end else if (s && !a) begin
            if (ln == 0) begin
                m_done_p = 1; m_count = 0;
            end else if (sd == 8'hFF) begin
                m_err_p = 1;
            end else begin
                m_words.delete();
                w = sd;
                m_words.push_back(w);
                for (int i = 0; i < int'(ln); i++) begin
                    w = nxt(w);
                    m_words.push_back(w);
                end
                m_count = 0;
                m_run   = 1;
            end
        end
    endfunction

    function automatic logic [19:0] m_exp();
        return {m_run, m_words[0], m_run | m_in_done, m_done_p, m_err_p, m_count};
    endfunction

    initial begin
        logic [7:0] w;
        int         beats;
        bit         seen;
        bit         s, a, r;
        logic [7:0] sd, ln;

        rst = 1'b1; start = 0; abort = 0; out_ready = 0; cfg_seed = 0; cfg_len = 0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_state", obs(), 20'h0);
        rst = 1'b0;

        // seed 01 len 4, ready high
        tbl.push_back(mk(1,0,1,8'h01,8'd4, 1,8'h01,1,0,0,8'd0));
        tbl.push_back(mk(0,0,1,8'h01,8'd4, 1,8'h03,1,0,0,8'd1));
        tbl.push_back(mk(0,0,1,8'h01,8'd4, 1,8'h07,1,0,0,8'd2));
        tbl.push_back(mk(0,0,1,8'h01,8'd4, 1,8'h0F,1,0,0,8'd3));
        tbl.push_back(mk(0,0,1,8'h01,8'd4, 0,8'h1E,1,1,0,8'd4));
        tbl.push_back(mk(0,0,1,8'h01,8'd4, 0,8'h1E,0,0,0,8'd4));
        // same run with ready toggling
        tbl.push_back(mk(1,0,0,8'h01,8'd4, 1,8'h01,1,0,0,8'd0));
        tbl.push_back(mk(0,0,1,8'h01,8'd4, 1,8'h03,1,0,0,8'd1));
        tbl.push_back(mk(0,0,0,8'h01,8'd4, 1,8'h03,1,0,0,8'd1));
        tbl.push_back(mk(0,0,1,8'h01,8'd4, 1,8'h07,1,0,0,8'd2));
        tbl.push_back(mk(0,0,0,8'h01,8'd4, 1,8'h07,1,0,0,8'd2));
        tbl.push_back(mk(0,0,1,8'h01,8'd4, 1,8'h0F,1,0,0,8'd3));
        tbl.push_back(mk(0,0,0,8'h01,8'd4, 1,8'h0F,1,0,0,8'd3));
        tbl.push_back(mk(0,0,1,8'h01,8'd4, 0,8'h1E,1,1,0,8'd4));
        tbl.push_back(mk(0,0,0,8'h01,8'd4, 0,8'h1E,0,0,0,8'd4));
        // illegal seed
        tbl.push_back(mk(1,0,1,8'hFF,8'd5, 0,8'h1E,0,0,1,8'd4));
        tbl.push_back(mk(0,0,1,8'hFF,8'd5, 0,8'h1E,0,0,0,8'd4));
        // zero length, also with illegal seed (length check wins)
        tbl.push_back(mk(1,0,1,8'h55,8'd0, 0,8'h1E,0,1,0,8'd0));
        tbl.push_back(mk(0,0,1,8'h55,8'd0, 0,8'h1E,0,0,0,8'd0));
        tbl.push_back(mk(1,0,1,8'hFF,8'd0, 0,8'h1E,0,1,0,8'd0));
        tbl.push_back(mk(0,0,1,8'hFF,8'd0, 0,8'h1E,0,0,0,8'd0));
        // seed 00 len 10, abort with ready on third beat
        tbl.push_back(mk(1,0,1,8'h00,8'd10, 1,8'h00,1,0,0,8'd0));
        tbl.push_back(mk(0,0,1,8'h00,8'd10, 1,8'h01,1,0,0,8'd1));
        tbl.push_back(mk(0,0,1,8'h00,8'd10, 1,8'h03,1,0,0,8'd2));
        tbl.push_back(mk(0,1,1,8'h00,8'd10, 0,8'h03,0,0,0,8'd2));
        tbl.push_back(mk(0,0,1,8'h00,8'd10, 0,8'h03,0,0,0,8'd2));
        // start together with abort in idle is ignored
        tbl.push_back(mk(1,1,1,8'h10,8'd3, 0,8'h03,0,0,0,8'd2));
        // start held: single-word runs back to back
        tbl.push_back(mk(1,0,1,8'h80,8'd1, 1,8'h80,1,0,0,8'd0));
        tbl.push_back(mk(1,0,1,8'h80,8'd1, 0,8'h00,1,1,0,8'd1));
        tbl.push_back(mk(1,1,1,8'h80,8'd1, 0,8'h00,0,0,0,8'd1));
        tbl.push_back(mk(1,0,1,8'h80,8'd1, 1,8'h80,1,0,0,8'd0));
        tbl.push_back(mk(0,0,1,8'h80,8'd1, 0,8'h00,1,1,0,8'd1));
        tbl.push_back(mk(0,0,1,8'h80,8'd1, 0,8'h00,0,0,0,8'd1));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].start, tbl[i].abort, tbl[i].ready, tbl[i].seed, tbl[i].len);
            chk($sformatf("vec%0d", i), obs(),
                {tbl[i].valid, tbl[i].data, tbl[i].busy, tbl[i].done, tbl[i].err, tbl[i].cnt});
        end

        // Asynchronous reset between edges mid-run
        apply(1, 0, 1, 8'h2A, 8'd20);
        apply(0, 0, 1, 8'h2A, 8'd20);
        apply(0, 0, 1, 8'h2A, 8'd20);
        #2 rst = 1'b1;
        #1 chk("async_rst_now", obs(), 20'h0);
        @(posedge clk); #1;
        chk("async_rst_hold", obs(), 20'h0);
        rst = 1'b0;
        apply(1, 0, 1, 8'h05, 8'd2);
        chk("post_rst_w0", obs(), {1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 8'd0});
        apply(0, 0, 1, 8'h05, 8'd2);
        chk("post_rst_w1", obs(), {1'b1, 8'h0B, 1'b1, 1'b0, 1'b0, 8'd1});
        apply(0, 0, 1, 8'h05, 8'd2);
        chk("post_rst_done", obs(), {1'b0, 8'h16, 1'b1, 1'b1, 1'b0, 8'd2});

        // Maximum legal length run
        apply(0, 0, 1, 8'h01, 8'd255);
        apply(1, 0, 1, 8'h01, 8'd255);
        beats = 0;
        seen  = 0;
        for (int c = 0; c < 300 && !seen; c++) begin
            if (out_valid) beats++;
            apply(0, 0, 1, 8'h01, 8'd255);
            if (done) seen = 1;
        end
        w = 8'h01;
        for (int i = 0; i < 255; i++) w = nxt(w);
        chk("max_len_done", {11'h0, seen, beats[7:0]}, {11'h0, 1'b1, 8'd255});
        chk("max_len_end", obs(), {1'b0, w, 1'b1, 1'b1, 1'b0, 8'd255});

        // Random traffic against the model
        rst = 1'b1;
        #2 rst = 1'b0;
        m_reset();
        @(posedge clk); #1;
        for (int c = 0; c < 4000; c++) begin
            s  = ($urandom % 4) == 0;
            a  = ($urandom % 20) == 0;
            r  = ($urandom % 4) != 0;
            sd = (($urandom % 8) == 0) ? 8'hFF : 8'($urandom);
            ln = (($urandom % 10) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
            apply(s, a, r, sd, ln);
            m_clock(s, a, r, sd, ln);
            chk($sformatf("rand%0d", c), obs(), m_exp());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
